// File: rtl/iob_fifo_ram_ctrl.sv
// FIFO controller for an external dual-port RAM: pointers, occupancy, status flags and the
// RAM port drive. Read data returns from the RAM one cycle after an accepted pop.
module iob_fifo_ram_ctrl #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned ALM_FULL_LVL  = (1 << ADDR_W) - 1,
  parameter int unsigned ALM_EMPTY_LVL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic              alm_full,
  output logic              alm_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [DATA_W-1:0] mem_w_data,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [DATA_W-1:0] mem_r_data
);

  localparam int unsigned    LvlW     = ADDR_W + 1;
  localparam logic [LvlW-1:0] Depth    = LvlW'(1 << ADDR_W);
  localparam logic [LvlW-1:0] AlmFull  = LvlW'(ALM_FULL_LVL);
  localparam logic [LvlW-1:0] AlmEmpty = LvlW'(ALM_EMPTY_LVL);

  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic              pop_valid_q, overflow_q, underflow_q;
  logic              push_acc, pop_acc;

  assign full      = (level_q == Depth);
  assign empty     = (level_q == '0);
  assign alm_full  = (level_q >= AlmFull);
  assign alm_empty = (level_q <= AlmEmpty);

  // Reset gates acceptance so the RAM sees no access while rst is high.
  assign push_acc = push & ~full & ~rst;
  assign pop_acc  = pop & ~empty & ~rst;

  assign mem_w_en   = push_acc;
  assign mem_w_addr = wptr_q;
  assign mem_w_data = push_data;
  assign mem_r_en   = pop_acc;
  assign mem_r_addr = rptr_q;

  assign pop_data  = mem_r_data;
  assign pop_valid = pop_valid_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    level_d = level_q;
    unique case ({push_acc, pop_acc})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_acc) wptr_q <= wptr_q + ADDR_W'(1);
      if (pop_acc)  rptr_q <= rptr_q + ADDR_W'(1);
      level_q     <= level_d;
      pop_valid_q <= pop_acc;
      // A new error in the same cycle as clr_err keeps the flag set.
      if (push && full)  overflow_q <= 1'b1;
      else if (clr_err)  overflow_q <= 1'b0;
      if (pop && empty)  underflow_q <= 1'b1;
      else if (clr_err)  underflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iob_fifo_ram_ctrl.sv
// Bench for iob_fifo_ram_ctrl: directed scenarios plus random traffic, checked every cycle
// against a queue-based model, with a behavioural dual-port RAM behind the controller.
module tb_iob_fifo_ram_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, push, pop, clr_err;
  logic [DW-1:0] push_data, pop_data, mem_w_data, mem_r_data;
  logic          pop_valid, full, empty, alm_full, alm_empty, overflow, underflow;
  logic [AW:0]   level;
  logic          mem_w_en, mem_r_en;
  logic [AW-1:0] mem_w_addr, mem_r_addr;

  always #5 clk = ~clk;

  iob_fifo_ram_ctrl #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .pop_data   (pop_data),
    .pop_valid  (pop_valid),
    .full       (full),
    .empty      (empty),
    .alm_full   (alm_full),
    .alm_empty  (alm_empty),
    .level      (level),
    .overflow   (overflow),
    .underflow  (underflow),
    .clr_err    (clr_err),
    .mem_w_en   (mem_w_en),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .mem_r_en   (mem_r_en),
    .mem_r_addr (mem_r_addr),
    .mem_r_data (mem_r_data)
  );

  // Registered-read dual-port RAM.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_w_en) ram[mem_w_addr] <= mem_w_data;
    if (mem_r_en) mem_r_data <= ram[mem_r_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: contents as a queue, plus counts of accepted pushes/pops since reset.
  logic [DW-1:0] q[$];
  int            wcnt, rcnt;
  bit            m_ovf, m_udf, m_valid, started;
  logic [DW-1:0] m_data;

  always @(posedge clk) begin
    bit f, e;
    if (rst) begin
      q.delete();
      wcnt = 0; rcnt = 0;
      m_ovf = 0; m_udf = 0; m_valid = 0;
      started = 1;
    end else if (started) begin
      f = (q.size() == DEPTH);
      e = (q.size() == 0);
      m_valid = pop && !e;
      if (m_valid) begin
        m_data = q.pop_front();
        rcnt = (rcnt + 1) % DEPTH;
      end
      if (push && !f) begin
        q.push_back(push_data);
        wcnt = (wcnt + 1) % DEPTH;
      end
      if (push && f) m_ovf = 1; else if (clr_err) m_ovf = 0;
      if (pop && e)  m_udf = 1; else if (clr_err) m_udf = 0;
    end
  end

  always @(negedge clk) begin
    int lv;
    bit ew, er;
    if (started) begin
      lv = q.size();
      chk("level", 32'(level), 32'(lv));
      chk("full", 32'(full), 32'(lv == DEPTH));
      chk("empty", 32'(empty), 32'(lv == 0));
      chk("alm_full", 32'(alm_full), 32'(lv >= DEPTH - 1));
      chk("alm_empty", 32'(alm_empty), 32'(lv <= 1));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_udf));
      chk("pop_valid", 32'(pop_valid), 32'(m_valid));
      if (m_valid) chk("pop_data", pop_data, m_data);
      ew = push && !rst && lv != DEPTH;
      er = pop && !rst && lv != 0;
      chk("mem_w_en", 32'(mem_w_en), 32'(ew));
      chk("mem_r_en", 32'(mem_r_en), 32'(er));
      if (ew) begin
        chk("mem_w_addr", 32'(mem_w_addr), 32'(wcnt));
        chk("mem_w_data", mem_w_data, push_data);
      end
      if (er) chk("mem_r_addr", 32'(mem_r_addr), 32'(rcnt));
    end
  end

  task automatic step(input bit p, input logic [DW-1:0] d, input bit po, input bit c,
                      input bit r);
    push = p; push_data = d; pop = po; clr_err = c; rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("lit_reset_empty", 32'(empty), 32'd1);
    chk("lit_reset_level", 32'(level), 32'd0);

    // Fill to full, then one rejected push.
    for (int i = 0; i < 16; i++) begin
      step(1, DW'(i), 0, 0, 0);
      if (i == 14) chk("lit_alm_full_15", 32'(alm_full), 32'd1);
    end
    chk("lit_full_level", 32'(level), 32'd16);
    chk("lit_full", 32'(full), 32'd1);
    chk("lit_no_ovf", 32'(overflow), 32'd0);
    step(1, 32'hAA, 0, 0, 0);
    chk("lit_ovf", 32'(overflow), 32'd1);
    chk("lit_ovf_level", 32'(level), 32'd16);

    // Drain back-to-back, then one rejected pop.
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0, 0);
      if (i == 0) chk("lit_first_pop", pop_data, 32'h0);
      if (i == 15) chk("lit_last_pop", pop_data, 32'hF);
    end
    chk("lit_drained_empty", 32'(empty), 32'd1);
    step(0, 0, 1, 0, 0);
    chk("lit_udf", 32'(underflow), 32'd1);
    chk("lit_udf_novalid", 32'(pop_valid), 32'd0);
    step(0, 0, 0, 1, 0);

    // Half full, then simultaneous push/pop across pointer wrap.
    for (int i = 0; i < 8; i++) step(1, $urandom, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, $urandom, 1, 0, 0);
    chk("lit_steady_level", 32'(level), 32'd8);

    // Full with push and pop together.
    for (int i = 0; i < 8; i++) step(1, $urandom, 0, 0, 0);
    step(1, $urandom, 1, 0, 0);
    chk("lit_fullpp_level", 32'(level), 32'd15);
    chk("lit_fullpp_ovf", 32'(overflow), 32'd1);

    // Empty with push and pop together.
    for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 32'h77, 1, 0, 0);
    chk("lit_emptypp_level", 32'(level), 32'd1);
    chk("lit_emptypp_udf", 32'(underflow), 32'd1);
    chk("lit_emptypp_valid", 32'(pop_valid), 32'd0);

    // clr_err coinciding with an overflow-causing push.
    for (int i = 0; i < 15; i++) step(1, $urandom, 0, 0, 0);
    step(1, $urandom, 0, 1, 0);
    chk("lit_clr_set_wins", 32'(overflow), 32'd1);
    step(0, 0, 0, 1, 0);
    chk("lit_clr_alone", 32'(overflow), 32'd0);

    // Reset right after an accepted pop.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 32'h100 + DW'(i), 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("lit_pre_rst_valid", 32'(pop_valid), 32'd1);
    step(0, 0, 0, 0, 1);
    chk("lit_rst_kill_valid", 32'(pop_valid), 32'd0);
    chk("lit_rst_level", 32'(level), 32'd0);
    chk("lit_rst_empty", 32'(empty), 32'd1);
    step(1, 32'h5A, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("lit_post_rst_data", pop_data, 32'h5A);

    // Random traffic with phases biased toward filling and draining.
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 300) % 2 == 1) ? 70 : 30;
      step($urandom_range(0, 99) < bias, $urandom, $urandom_range(0, 99) < (100 - bias),
           $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end
    step(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
